mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one single-port instruction/data memory between two requesters: the instruction fetch port (IF) and the load/store port (MEM stage).
- Sits between the openmips core and the external SRAM/ROM model.
- The data port normally wins; a starvation counter forces periodic fetch grants.
- Drives per-port stall requests so the pipeline controller can freeze stages while an access is pending.

Parameters:
- ADDR_W, 32, address width (matches InstAddrBus).
- DATA_W, 32, data width (matches RegBus).
- STARVE_LIMIT, 4, consecutive data grants that may occur while IF is waiting before IF is forced to win (1..15).
- TIMEOUT, 16, cycles in BUSY without ram_ack_i before the access is aborted with an error (2..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- if_req_i  in  1  fetch request; held with if_addr_i stable until if_ack_o.
- if_addr_i  in  ADDR_W  fetch address.
- if_rdata_o  out  DATA_W  fetched instruction, valid while if_ack_o=1.
- if_ack_o  out  1  one-cycle completion pulse for IF.
- if_stall_o  out  1  IF stall request to the pipeline controller.
- mem_req_i  in  1  data request; held with all mem_* inputs stable until mem_ack_o.
- mem_we_i  in  1  1 = store, 0 = load.
- mem_sel_i  in  4  byte enables.
- mem_addr_i  in  ADDR_W  data address.
- mem_wdata_i  in  DATA_W  store data.
- mem_rdata_o  out  DATA_W  load data, valid while mem_ack_o=1.
- mem_ack_o  out  1  one-cycle completion pulse for MEM.
- mem_stall_o  out  1  MEM stall request.
- bus_err_o  out  1  one-cycle pulse together with the ack of a timed-out access.
- ram_ce_o  out  1  memory chip enable.
- ram_we_o  out  1  memory write enable.
- ram_sel_o  out  4  memory byte enables.
- ram_addr_o  out  ADDR_W  memory address.
- ram_wdata_o  out  DATA_W  memory write data.
- ram_rdata_i  in  DATA_W  memory read data, valid when ram_ack_i=1.
- ram_ack_i  in  1  memory completion; may assert 1 or more cycles after ram_ce_o rises.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; starve_cnt=0; timer=0.
  - All registered outputs are 0: ram_ce_o, ram_we_o, ram_sel_o, ram_addr_o, ram_wdata_o, if_ack_o, mem_ack_o, if_rdata_o, mem_rdata_o, bus_err_o.
  - Reset mid-access drops ram_ce_o immediately. No ack is issued for the aborted access; requesters re-request after reset.
- FSM states: IDLE, BUSY, RESP. All ram_* outputs are registered.
- IDLE:
  - If mem_req_i=1 and (if_req_i=0 or starve_cnt<STARVE_LIMIT): grant MEM.
  - Else if if_req_i=1: grant IF.
  - On a grant, the next edge latches owner and the request fields into the ram_* registers, sets ram_ce_o=1, clears timer, and moves to BUSY.
  - IF fetches drive ram_we_o=0 and ram_sel_o=4'b1111.
- starve_cnt update at each grant:
  - MEM granted while if_req_i=1: starve_cnt+1, saturating at 15.
  - IF granted: starve_cnt reset to 0.
  - MEM granted while if_req_i=0: starve_cnt unchanged.
- BUSY:
  - ram_* held constant; timer increments every cycle.
  - If ram_ack_i=1: the next edge clears ram_ce_o/ram_we_o, registers ram_rdata_i into the owner's rdata_o (stores return 0), pulses the owner's ack_o for one cycle, and moves to RESP.
  - Else if timer==TIMEOUT-1: same transition with rdata=0 and bus_err_o=1 in the ack cycle.
- RESP:
  - Ack cycle; ram_ce_o=0. Next state is always IDLE.
  - The requester must deassert or change its request in this cycle. A request still high in IDLE is treated as a new access.
- Latency: request seen in IDLE at cycle 0 → ram_ce_o=1 at cycle 1 → ram_ack_i at cycle 1+w → ack at cycle 2+w. Minimum 3 cycles per access. ram_ack_i outside BUSY is ignored.
- Stall outputs (combinational): if_stall_o = if_req_i & ~if_ack_o; mem_stall_o = mem_req_i & ~mem_ack_o.
- Simultaneous requests in IDLE: MEM wins unless starve_cnt>=STARVE_LIMIT. The loser stays pending and is arbitrated again at the next IDLE.

Decomposition:
- Shared defines file:
  - FSM state encodings (`ArbIdle`, `ArbBusy`, `ArbResp`, 2 bits).
  - Owner encoding (`OwnerIf`, `OwnerMem`).
  - Reuse RegBus/InstAddrBus widths.
- One natural sub-module, arb_timeout_cnt: a loadable counter with a terminal-count flag, used for the BUSY timer.

Test Plan:
- Reset mid-access: rst=0 while in BUSY → ram_ce_o=0 in the same cycle; no ack pulse; the FSM resumes from IDLE after release.
- Single fetch: if_req_i=1, if_addr_i=0x00000004, RAM acks 1 cycle after ce with 0x34010100 → ram_addr_o=0x4, ram_we_o=0, if_ack_o=1 at cycle 3, if_rdata_o=0x34010100.
- Store: mem_req_i=1, mem_we_i=1, mem_sel_i=4'b0011, mem_addr_i=0x100, mem_wdata_i=0xDEADBEEF, 2-cycle RAM → ram_we_o=1, ram_sel_o=0011, ram_wdata_o=0xDEADBEEF; mem_ack_o at cycle 4.
- Contention: both requests held continuously with 0-wait RAM → grant order MEM,MEM,MEM,MEM,IF,MEM...; if_stall_o stays 1 until IF's ack.
- Timeout: ram_ack_i never asserted, TIMEOUT=16 → owner ack and bus_err_o=1 in the cycle after the 16th BUSY cycle; rdata=0.
- Spurious ram_ack_i=1 in IDLE with no requests → no ack outputs and no state change.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and bus widths for the IF/MEM single-port memory arbiter.
package mem_arbiter_pkg;

  localparam int RegBus      = 32;
  localparam int InstAddrBus = 32;

  localparam logic [3:0] SelAll = 4'b1111;

  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
    ArbBusy = 2'd1,
    ArbResp = 2'd2
  } arb_state_e;

  typedef enum logic {
    OwnerIf  = 1'b0,
    OwnerMem = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Loadable up-counter with a terminal-count flag; times how long an access sits in BUSY.
module arb_timeout_cnt #(
  parameter int W      = 8,
  parameter int TC_VAL = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == W'(TC_VAL));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the IF and MEM ports onto one single-port memory; MEM has priority,
// with a starvation counter that forces an IF grant after STARVE_LIMIT data wins.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = InstAddrBus,
  parameter int DATA_W       = RegBus,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  output logic              if_stall_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_ack_o,
  output logic              mem_stall_o,
  output logic              bus_err_o,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [3:0]        ram_sel_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  input  logic              ram_ack_i,
  output logic [1:0]        dbg_state_o
);

  // Handshake: a requester raises req with its fields stable and holds them until
  // its one-cycle ack; the ack cycle (RESP) is where it must drop or change req.
  arb_state_e  state_q, state_d;
  arb_owner_e  owner_q, owner_d;
  logic [3:0]  starve_q, starve_d;
  logic        ce_q, ce_d, we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
  logic        if_ack_q, if_ack_d, mem_ack_q, mem_ack_d, err_q, err_d;
  logic        grant, grant_mem, timer_tc;

  assign grant_mem = mem_req_i && (!if_req_i || (starve_q < 4'(STARVE_LIMIT)));

  arb_timeout_cnt #(.W(8), .TC_VAL(TIMEOUT - 1)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (grant),
    .en_i  (state_q == ArbBusy),
    .tc_o  (timer_tc)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    ce_d        = ce_q;
    we_d        = we_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    err_d       = 1'b0;
    grant       = 1'b0;
    case (state_q)
      ArbIdle: begin
        if (grant_mem) begin
          grant   = 1'b1;
          owner_d = OwnerMem;
          we_d    = mem_we_i;
          sel_d   = mem_sel_i;
          addr_d  = mem_addr_i;
          wdata_d = mem_wdata_i;
          if (if_req_i && starve_q != 4'hF) starve_d = starve_q + 4'd1;
        end else if (if_req_i) begin
          grant    = 1'b1;
          owner_d  = OwnerIf;
          we_d     = 1'b0;
          sel_d    = SelAll;
          addr_d   = if_addr_i;
          wdata_d  = '0;
          starve_d = 4'd0;
        end
        if (grant) begin
          ce_d    = 1'b1;
          state_d = ArbBusy;
        end
      end
      ArbBusy: begin
        // A real ack wins over a timeout that expires in the same cycle.
        if (ram_ack_i || timer_tc) begin
          ce_d    = 1'b0;
          we_d    = 1'b0;
          err_d   = !ram_ack_i;
          state_d = ArbResp;
          if (owner_q == OwnerMem) begin
            mem_ack_d   = 1'b1;
            mem_rdata_d = (ram_ack_i && !we_q) ? ram_rdata_i : '0;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = ram_ack_i ? ram_rdata_i : '0;
          end
        end
      end
      ArbResp: state_d = ArbIdle;
      default: state_d = ArbIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ArbIdle;
      owner_q     <= OwnerIf;
      starve_q    <= '0;
      ce_q        <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      ce_q        <= ce_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      err_q       <= err_d;
    end
  end

  assign ram_ce_o    = ce_q;
  assign ram_we_o    = we_q;
  assign ram_sel_o   = sel_q;
  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign mem_rdata_o = mem_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign mem_ack_o   = mem_ack_q;
  assign bus_err_o   = err_q;
  assign if_stall_o  = if_req_i & ~if_ack_q;
  assign mem_stall_o = mem_req_i & ~mem_ack_q;
  assign dbg_state_o = state_q;

endmodule
